// File: rtl/display_pkg.sv
// display_pkg -- shared definitions for the display sequencer.
//   mode_e   : encoding of the 2-bit Mode input
//   state_e  : SHOW / BLANK sequencer states
//   next_sel : step/auto successor of a display selection
package display_pkg;

    localparam int NUM_SOURCES_DEFAULT = 24;
    localparam int SEL_W               = 5;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_STEP   = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_e;

    // Successor used by STEP/AUTO; anything at or above the last source
    // (possible after a MANUAL load) wraps back to 0.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel,
                                                   input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] res;
        if (sel < last) begin
            res = sel + 5'd1;
        end else begin
            res = 5'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce -- synchronizes, debounces and edge-detects an active-low
// pushbutton.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   btn_n_i : raw active-low button, asynchronous to clk_i
//   level_o : debounced button level (1 = released)
//   press_o : one-cycle pulse on a debounced 1->0 transition
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive synchronized samples that disagree with the accepted
    // level; a sample agreeing with the level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
            press_d = level_q & ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Two-flop synchronizer plus debounce state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/display_sequencer.sv
// display_sequencer -- selects which source drives the display and blanks
// the display for a few cycles after every selection change.
//   Clock          : system clock, rising edge
//   Reset          : asynchronous active-high reset
//   Mode           : 00 MANUAL, 01 STEP, 10 AUTO, 11 HOLD
//   Switch_Select  : selection loaded in MANUAL mode
//   Step_Button_n  : active-low step pushbutton (asynchronous)
//   Display_Select : registered selection to the display mux
//   Display_Enable : registered, 1 blanks the display
//   Wrap_Pulse     : one cycle high when STEP/AUTO wraps last source -> 0
module display_sequencer
    import display_pkg::*;
#(
    parameter int NUM_SOURCES     = NUM_SOURCES_DEFAULT,
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int BLANK_CYCLES    = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [1:0]       Mode,
    input  logic [SEL_W-1:0] Switch_Select,
    input  logic             Step_Button_n,
    output logic [SEL_W-1:0] Display_Select,
    output logic             Display_Enable,
    output logic             Wrap_Pulse
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SOURCES - 1);

    state_e           state_q,  state_d;
    logic [SEL_W-1:0] sel_q,    sel_d;
    logic             enable_q, enable_d;
    logic             wrap_q,   wrap_d;
    logic [DW-1:0]    dwell_q,  dwell_d;
    logic [BW-1:0]    blank_q,  blank_d;
    mode_e            mode_q;
    mode_e            mode_s;
    logic             mode_chg_s;
    logic             adv_s;
    logic             btn_level_s;
    logic             btn_press_s;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .btn_n_i(Step_Button_n),
        .level_o(btn_level_s),
        .press_o(btn_press_s)
    );

    assign mode_s     = mode_e'(Mode);
    // Mode is acted on directly in SHOW; a change seen while blanking only
    // matters once SHOW resumes, since BLANK evaluates no requests.
    assign mode_chg_s = (mode_s != mode_q);

    // Next-state logic for the SHOW/BLANK sequencer and its counters.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        enable_d = enable_q;
        wrap_d   = 1'b0;
        dwell_d  = dwell_q;
        blank_d  = blank_q;
        adv_s    = 1'b0;
        case (state_q)
            ST_SHOW: begin
                enable_d = 1'b0;
                blank_d  = '0;
                case (mode_s)
                    MODE_MANUAL: adv_s = (Switch_Select != sel_q);
                    MODE_STEP:   adv_s = btn_press_s & ~btn_level_s;
                    MODE_AUTO:   adv_s = ~mode_chg_s & (dwell_q == DW'(DWELL_CYCLES - 1));
                    MODE_HOLD:   adv_s = 1'b0;
                    default:     adv_s = 1'b0;
                endcase
                if (adv_s) begin
                    state_d  = ST_BLANK;
                    enable_d = 1'b1;
                    dwell_d  = '0;
                    if (mode_s == MODE_MANUAL) begin
                        sel_d = Switch_Select;
                    end else begin
                        sel_d  = next_sel(sel_q, LAST_SEL);
                        wrap_d = (sel_q == LAST_SEL);
                    end
                end else if ((mode_s == MODE_AUTO) && !mode_chg_s) begin
                    dwell_d = dwell_q + 1'b1;
                end else begin
                    dwell_d = '0;
                end
            end
            ST_BLANK: begin
                dwell_d = '0;
                if (blank_q == BW'(BLANK_CYCLES - 1)) begin
                    state_d  = ST_SHOW;
                    enable_d = 1'b0;
                    blank_d  = '0;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_SHOW;
                enable_d = 1'b0;
                dwell_d  = '0;
                blank_d  = '0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_SHOW;
            sel_q    <= '0;
            enable_q <= 1'b0;
            wrap_q   <= 1'b0;
            dwell_q  <= '0;
            blank_q  <= '0;
            mode_q   <= MODE_MANUAL;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            wrap_q   <= wrap_d;
            dwell_q  <= dwell_d;
            blank_q  <= blank_d;
            mode_q   <= mode_s;
        end
    end

    assign Display_Select = sel_q;
    assign Display_Enable = enable_q;
    assign Wrap_Pulse     = wrap_q;

endmodule

// File: tb/tb_display_sequencer.sv
module tb_display_sequencer;

    localparam int NSRC  = 24;
    localparam int DWELL = 10;
    localparam int BLANK = 2;
    localparam int DEB   = 3;

    logic       Clock;
    logic       Reset;
    logic [1:0] Mode;
    logic [4:0] Switch_Select;
    logic       Step_Button_n;
    logic [4:0] Display_Select;
    logic       Display_Enable;
    logic       Wrap_Pulse;

    int n_total = 0;
    int n_pass  = 0;

    display_sequencer #(
        .NUM_SOURCES(NSRC), .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Mode(Mode),
        .Switch_Select(Switch_Select), .Step_Button_n(Step_Button_n),
        .Display_Select(Display_Select), .Display_Enable(Display_Enable),
        .Wrap_Pulse(Wrap_Pulse)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0] mode;
        logic [4:0] sw;
        logic       btn;
        int         cycles;
        logic [4:0] e_sel;
        logic       e_en;
        logic       e_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add_vec(input logic [1:0] m, input logic [4:0] sw, input logic b, input int c,
                           input logic [4:0] es, input logic ee, input logic ew);
        vec_t v;
        v.mode = m; v.sw = sw; v.btn = b; v.cycles = c;
        v.e_sel = es; v.e_en = ee; v.e_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        Reset = 1'b1; Mode = 2'd0; Switch_Select = 5'd0; Step_Button_n = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Wait (bounded) for Display_Select to leave the given value.
    task automatic wait_change(input string name, input logic [4:0] old);
        int n;
        n = 0;
        while (Display_Select == old && n < 40) begin
            @(negedge Clock);
            n++;
        end
        chk({name, "_timeout"}, int'(Display_Select != old), 1);
    endtask

    // ---------------- reference model (random phase) ----------------
    int   m_sel, m_dwell, m_blank_left, m_run;
    bit   m_en, m_wrap, m_level, m_run_val, m_press_pend;
    int   m_prev_mode;
    bit   raw_q[$];

    task automatic model_reset();
        m_sel = 0; m_dwell = 0; m_blank_left = 0; m_run = 0;
        m_en = 0; m_wrap = 0; m_level = 1; m_run_val = 1; m_press_pend = 0;
        m_prev_mode = 0;
        raw_q.delete();
        raw_q.push_back(1'b1);
        raw_q.push_back(1'b1);
    endtask

    // One clock edge of the specified behaviour, given the inputs held
    // during the preceding cycle.
    task automatic model_step(input int m, input int sw, input bit b);
        bit press_now;
        bit changed;
        bit adv;
        bit samp;
        press_now = m_press_pend;
        changed   = (m != m_prev_mode);
        adv       = 0;
        m_wrap    = 0;
        if (m_blank_left > 0) begin
            m_blank_left--;
            m_dwell = 0;
            if (m_blank_left == 0) m_en = 0;
        end else begin
            if (m == 0) adv = (sw != m_sel);
            else if (m == 1) adv = press_now;
            else if (m == 2) adv = !changed && (m_dwell == DWELL - 1);
            if (adv) begin
                if (m == 0) begin
                    m_sel = sw;
                end else begin
                    m_wrap = (m_sel == NSRC - 1);
                    m_sel  = (m_sel < NSRC - 1) ? m_sel + 1 : 0;
                end
                m_en = 1; m_blank_left = BLANK; m_dwell = 0;
            end else if (m == 2 && !changed) begin
                m_dwell++;
            end else begin
                m_dwell = 0;
            end
        end
        m_prev_mode = m;
        raw_q.push_back(b);
        samp = raw_q.pop_front();
        if (samp == m_run_val) m_run++;
        else begin m_run_val = samp; m_run = 1; end
        m_press_pend = 0;
        if (m_run_val != m_level && m_run >= DEB) begin
            m_level = m_run_val;
            m_press_pend = (m_level == 0);
        end
    endtask

    initial begin
        logic [4:0] prev;
        int hold;
        bit b;

        // ---------------- reset state ----------------
        Reset = 1'b1; Mode = 2'd0; Switch_Select = 5'd0; Step_Button_n = 1'b1;
        @(negedge Clock);
        chk("reset_sel", Display_Select, 0);
        chk("reset_en", Display_Enable, 0);
        chk("reset_wrap", Wrap_Pulse, 0);
        do_reset();

        // ---------------- table-driven vectors ----------------
        add_vec(2'd0, 5'd0,  1'b1, 3,  5'd0,  1'b0, 1'b0);
        add_vec(2'd0, 5'd7,  1'b1, 1,  5'd7,  1'b1, 1'b0);
        add_vec(2'd0, 5'd7,  1'b1, 1,  5'd7,  1'b1, 1'b0);
        add_vec(2'd0, 5'd7,  1'b1, 1,  5'd7,  1'b0, 1'b0);
        add_vec(2'd3, 5'd3,  1'b1, 5,  5'd7,  1'b0, 1'b0);
        add_vec(2'd0, 5'd23, 1'b1, 1,  5'd23, 1'b1, 1'b0);
        add_vec(2'd0, 5'd23, 1'b1, 2,  5'd23, 1'b0, 1'b0);
        add_vec(2'd2, 5'd23, 1'b1, 10, 5'd23, 1'b0, 1'b0);
        add_vec(2'd2, 5'd23, 1'b1, 1,  5'd0,  1'b1, 1'b1);
        add_vec(2'd2, 5'd23, 1'b1, 1,  5'd0,  1'b1, 1'b0);
        add_vec(2'd2, 5'd23, 1'b1, 1,  5'd0,  1'b0, 1'b0);
        add_vec(2'd3, 5'd23, 1'b1, 20, 5'd0,  1'b0, 1'b0);
        add_vec(2'd1, 5'd23, 1'b1, 5,  5'd0,  1'b0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            Mode = vecs[i].mode; Switch_Select = vecs[i].sw; Step_Button_n = vecs[i].btn;
            repeat (vecs[i].cycles) @(negedge Clock);
            chk($sformatf("vec%0d_sel", i), Display_Select, vecs[i].e_sel);
            chk($sformatf("vec%0d_en", i), Display_Enable, vecs[i].e_en);
            chk($sformatf("vec%0d_wrap", i), Wrap_Pulse, vecs[i].e_wrap);
        end

        // ---------------- STEP: clean press and glitch ----------------
        do_reset();
        Switch_Select = 5'd5;
        repeat (4) @(negedge Clock);
        chk("step_setup", Display_Select, 5);
        Mode = 2'd1; Step_Button_n = 1'b0;
        wait_change("step", 5'd5);
        chk("step_sel", Display_Select, 6);
        chk("step_blank1", Display_Enable, 1);
        @(negedge Clock);
        chk("step_blank2", Display_Enable, 1);
        @(negedge Clock);
        chk("step_show", Display_Enable, 0);
        Step_Button_n = 1'b1;
        repeat (10) @(negedge Clock);
        chk("step_single", Display_Select, 6);
        Step_Button_n = 1'b0;
        repeat (2) @(negedge Clock);
        Step_Button_n = 1'b1;
        repeat (10) @(negedge Clock);
        chk("glitch_sel", Display_Select, 6);
        chk("glitch_en", Display_Enable, 0);

        // ---------------- wrap ----------------
        Mode = 2'd0; Switch_Select = 5'd23;
        repeat (4) @(negedge Clock);
        Mode = 2'd1; Step_Button_n = 1'b0;
        wait_change("wrap", 5'd23);
        chk("wrap_sel", Display_Select, 0);
        chk("wrap_pulse", Wrap_Pulse, 1);
        Step_Button_n = 1'b1;
        @(negedge Clock);
        chk("wrap_pulse_end", Wrap_Pulse, 0);
        repeat (10) @(negedge Clock);

        // ---------------- AUTO period and HOLD ----------------
        do_reset();
        Mode = 2'd2;
        wait_change("auto_first", 5'd0);
        for (int p = 0; p < 3; p++) begin
            prev = Display_Select;
            repeat (11) @(negedge Clock);
            chk($sformatf("auto_dwell%0d", p), Display_Select, prev);
            @(negedge Clock);
            chk($sformatf("auto_step%0d", p), Display_Select, prev + 5'd1);
        end
        repeat (5) @(negedge Clock);
        Mode = 2'd3;
        prev = Display_Select;
        repeat (30) @(negedge Clock);
        chk("hold_sel", Display_Select, prev);
        chk("hold_en", Display_Enable, 0);

        // ---------------- MANUAL out-of-range ----------------
        do_reset();
        Switch_Select = 5'd27;
        wait_change("manual", 5'd0);
        chk("manual_sel", Display_Select, 27);
        chk("manual_en1", Display_Enable, 1);
        chk("manual_wrap1", Wrap_Pulse, 0);
        @(negedge Clock);
        chk("manual_en2", Display_Enable, 1);
        chk("manual_wrap2", Wrap_Pulse, 0);
        @(negedge Clock);
        chk("manual_show", Display_Enable, 0);
        chk("manual_hold", Display_Select, 27);

        // ---------------- press lands inside BLANK ----------------
        do_reset();
        Step_Button_n = 1'b0;
        repeat (4) @(negedge Clock);
        Switch_Select = 5'd9;
        @(negedge Clock);
        chk("pblank_load", Display_Select, 9);
        chk("pblank_en", Display_Enable, 1);
        Mode = 2'd1;
        repeat (3) @(negedge Clock);
        Step_Button_n = 1'b1;
        repeat (12) @(negedge Clock);
        chk("pblank_dropped", Display_Select, 9);

        // ---------------- reset mid-BLANK ----------------
        Mode = 2'd0; Switch_Select = 5'd3;
        wait_change("rst_blank", 5'd9);
        chk("rst_blank_pre", Display_Enable, 1);
        Reset = 1'b1;
        #1;
        chk("rst_async_sel", Display_Select, 0);
        chk("rst_async_en", Display_Enable, 0);
        chk("rst_async_wrap", Wrap_Pulse, 0);
        @(negedge Clock);
        Reset = 1'b0;

        // ---------------- randomized against reference model ----------------
        do_reset();
        model_reset();
        b = 1'b1; hold = 1;
        for (int i = 0; i < 3000; i++) begin
            if (Display_Select != m_sel[4:0] || Display_Enable != m_en || Wrap_Pulse != m_wrap) begin
                $display("FAIL rand cyc%0d: sel/en/wrap got %0d/%0d/%0d, expected %0d/%0d/%0d",
                         i, Display_Select, Display_Enable, Wrap_Pulse, m_sel, m_en, m_wrap);
            end else begin
                n_pass++;
            end
            n_total++;
            if ($urandom_range(0, 11) == 0) Mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) Switch_Select = 5'($urandom_range(0, 31));
            hold--;
            if (hold <= 0) begin
                b = ~b;
                hold = $urandom_range(1, 8);
            end
            Step_Button_n = b;
            model_step(int'(Mode), int'(Switch_Select), b);
            @(negedge Clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
